column_scanout: RTL and testbench
=================================

// Module: column_scanout
// PURPOSE
// - Consumer end of the raycaster column interface: accepts one wall span per screen
//   column (x, drawStart, drawEnd, 12-bit colour) and rasterises it row-major to VGA.
// - Double-buffered span memory (2 banks x 640 entries). The raycaster writes the back
//   bank while the front bank is scanned; banks swap at vblank start after frame_done.
// - Sits between the raycaster column loop and the VGA pins; owns 640x480@60 timing.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line (also span-memory depth)
// - H_FP 16, H_SYNC 96, H_BP 48 : horizontal porch/sync widths; line total 800
// - V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 : vertical timing; frame total 525
// - BG_COLOR 12'h000 : colour outside the span and before the first swap
// PORTS
// - clk          in   1   system clock
// - rst          in   1   synchronous, active-high reset
// - pix_en       in   1   pixel-rate strobe (1 of 4 clk at 100 MHz); all raster state advances only on pix_en
// - col_valid    in   1   writer has a column span
// - col_ready    out  1   block accepts the span this cycle
// - col_x        in   10  column index, 0..639
// - col_start    in   9   first lit row (inclusive)
// - col_end      in   9   last lit row (exclusive)
// - col_color    in   12  {R[3:0],G[3:0],B[3:0]}; side shading is already applied by the writer
// - frame_done   in   1   1-clk pulse: back bank complete, request swap
// - frame_swap   out  1   1-clk pulse when the swap takes effect
// - vga_hs       out  1   hsync, active low
// - vga_vs       out  1   vsync, active low
// - vga_r/g/b    out  4   pixel colour, 0 outside the active area
// BEHAVIOUR
// - Reset: hcnt=vcnt=0; vga_hs=vga_vs=1; vga_rgb=0; col_ready=1; frame_swap=0;
//   front=bank0; swap_pend=0; shown_valid=0. Memory is not cleared; shown_valid masks it.
// - Write handshake: transfer when col_valid&&col_ready on any clk (pix_en not required).
//   - Write goes to the back bank at col_x. col_x>=640: accepted and dropped.
//   - col_start>=col_end: empty span, column shows BG_COLOR.
// - frame_done: sets swap_pend; col_ready=!swap_pend.
//   - frame_done while swap_pend=1: ignored.
//   - col write and frame_done in the same clk: the write lands in the old back bank,
//     then swap_pend is set.
// - Swap: on the pix_en with hcnt==0 && vcnt==V_ACTIVE and swap_pend=1:
//   front^=1, swap_pend=0, shown_valid=1, frame_swap=1 for that clk.
//   The bank never changes mid-visible-frame (no tearing).
// - Counters: hcnt 0..799 wraps, and vcnt increments on that wrap; vcnt 0..524 wraps.
// - Syncs: hs low for hcnt in [656,752); vs low for vcnt in [490,492).
// - Pipeline: stage0 counters -> stage1 front-bank read at hcnt -> stage2 compare/registered pins.
//   - hs, vs and the active flag are delayed 2 pix_en to stay aligned with rgb.
//   - Fixed latency from counter to pins: 2 pix_en ticks.
// - Pixel rule: lit iff active && shown_valid && start<=vcnt<end.
//   Lit pixels output the span colour; all others output BG_COLOR in the active area, 0 in blanking.
// - Read/write to the same address never collide: they always target different banks.
// - rst mid-frame: all state returns to reset values next clk; any pending swap is lost.
// STRUCTURE
// - Package raycast_pkg: timing constants, SCREEN_W/H, col_span_t {start[8:0],end[8:0],color[11:0]}.
//   raycast_pkg is shared with the raycaster.
// - Sub-module vga_timing: hcnt/vcnt, hs/vs, active, vblank_start strobe.
// - Span memory: 2x640x30-bit simple dual-port, inferred as BRAM.
// TESTING
// - After reset, run 1 frame: rgb=0 everywhere; hs low exactly 96 pix/line; vs low exactly 2 lines; 800x525 total.
// - Write all 640 cols start=100,end=380,color=12'hF00, then frame_done:
//   - frame_swap pulses at vcnt=480,hcnt=0.
//   - Next frame: rows 100..379 = F00, rows 0..99 and 380..479 = 000.
// - Check latency: pixel for x=0 appears on the pins 2 pix_en ticks after hcnt=0.
// - frame_done then col_valid held high: col_ready=0 until the swap, writes resume after;
//   the displayed frame is unchanged until the next swap.
// - Spans with col_x=700 and col_start=300,col_end=200 on x=5: no effect, and column 5 is black.
// - Assert rst at vcnt=240 with swap_pend=1: pins go idle, no swap occurs, and col_ready=1 next clk.

Source files
------------

// File: rtl/raycast_pkg.sv
// raycast_pkg: raster timing, screen size and column span type shared with the raycaster
package raycast_pkg;
   localparam int H_ACTIVE = 640;
   localparam int H_FP = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP = 33;
   localparam int SCREEN_W = H_ACTIVE;
   localparam int SCREEN_H = V_ACTIVE;
   localparam logic [11:0] BG_COLOR = 12'h000;
   typedef struct packed {
      logic [8:0]  start;
      logic [8:0]  stop;
      logic [11:0] color;
   } col_span_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate raster counters, sync windows, active flag and vblank strobe
module vga_timing
   import raycast_pkg::*;
#(
   parameter int H_ACTIVE = raycast_pkg::H_ACTIVE,
   parameter int H_FP = raycast_pkg::H_FP,
   parameter int H_SYNC = raycast_pkg::H_SYNC,
   parameter int H_BP = raycast_pkg::H_BP,
   parameter int V_ACTIVE = raycast_pkg::V_ACTIVE,
   parameter int V_FP = raycast_pkg::V_FP,
   parameter int V_SYNC = raycast_pkg::V_SYNC,
   parameter int V_BP = raycast_pkg::V_BP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   output logic [9:0] hcnt,
   output logic [9:0] vcnt,
   output logic       hs,
   output logic       vs,
   output logic       active,
   output logic       vblank_start
);
   localparam logic [9:0] HA = 10'(H_ACTIVE);
   localparam logic [9:0] HS_ON = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VA = 10'(V_ACTIVE);
   localparam logic [9:0] VS_ON = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   // raster position steps once per pixel strobe; vcnt advances on each line wrap
   always_ff @(posedge clk)
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_en) begin
         hcnt <= (hcnt == H_LAST) ? '0 : hcnt + 10'd1;
         if (hcnt == H_LAST) vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end
   // sync windows, visible area and the first pixel of vblank decoded from the counters
   always_comb begin
      hs = !(hcnt >= HS_ON && hcnt < HS_OFF);
      vs = !(vcnt >= VS_ON && vcnt < VS_OFF);
      active = hcnt < HA && vcnt < VA;
      vblank_start = pix_en && hcnt == '0 && vcnt == VA;
   end
endmodule

// File: rtl/column_scanout.sv
// column_scanout: double-buffered column span memory rasterised row-major onto VGA pins
module column_scanout
   import raycast_pkg::*;
#(
   parameter int H_ACTIVE = raycast_pkg::H_ACTIVE,
   parameter int H_FP = raycast_pkg::H_FP,
   parameter int H_SYNC = raycast_pkg::H_SYNC,
   parameter int H_BP = raycast_pkg::H_BP,
   parameter int V_ACTIVE = raycast_pkg::V_ACTIVE,
   parameter int V_FP = raycast_pkg::V_FP,
   parameter int V_SYNC = raycast_pkg::V_SYNC,
   parameter int V_BP = raycast_pkg::V_BP,
   parameter logic [11:0] BG_COLOR = raycast_pkg::BG_COLOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        col_valid,
   output logic        col_ready,
   input  logic [9:0]  col_x,
   input  logic [8:0]  col_start,
   input  logic [8:0]  col_end,
   input  logic [11:0] col_color,
   input  logic        frame_done,
   output logic        frame_swap,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);
   localparam int AW = $clog2(H_ACTIVE);
   localparam logic [9:0] HA = 10'(H_ACTIVE);
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic hs;
   logic vs;
   logic active;
   logic vblank_start;
   logic front;
   logic swap_pend;
   logic shown_valid;
   logic wr_en;
   col_span_t mem [2][H_ACTIVE];
   col_span_t rd_span;
   logic [9:0] s1_vcnt;
   logic s1_hs;
   logic s1_vs;
   logic s1_active;
   logic lit;
   logic [11:0] pix;
   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
      .hs(hs), .vs(vs), .active(active), .vblank_start(vblank_start)
   );
   // writer is held off only while a finished back bank waits for vblank
   always_comb begin
      col_ready = !swap_pend;
      wr_en = col_valid && col_ready && col_x < HA;
      frame_swap = !rst && vblank_start && swap_pend;
   end
   // bank ownership: swap only at vblank start so a visible frame never tears
   always_ff @(posedge clk)
      if (rst) begin
         front <= 1'b0;
         swap_pend <= 1'b0;
         shown_valid <= 1'b0;
      end else if (frame_swap) begin
         front <= !front;
         swap_pend <= 1'b0;
         shown_valid <= 1'b1;
      end else if (frame_done) begin
         swap_pend <= 1'b1;
      end
   // back-bank write port; the scan side only ever reads the other bank
   always_ff @(posedge clk)
      if (wr_en) mem[!front][col_x[AW-1:0]] <= '{start: col_start, stop: col_end, color: col_color};
   // front-bank read port, one pixel strobe behind the counters
   always_ff @(posedge clk)
      if (pix_en) rd_span <= mem[front][hcnt[AW-1:0]];
   // raster controls delayed alongside the memory read
   always_ff @(posedge clk)
      if (rst) begin
         s1_hs <= 1'b1;
         s1_vs <= 1'b1;
         s1_active <= 1'b0;
         s1_vcnt <= '0;
      end else if (pix_en) begin
         s1_hs <= hs;
         s1_vs <= vs;
         s1_active <= active;
         s1_vcnt <= vcnt;
      end
   // span test: a row is lit when it falls inside [start, stop) of a shown column
   always_comb begin
      lit = s1_active && shown_valid && {1'b0, rd_span.start} <= s1_vcnt && {1'b0, rd_span.stop} > s1_vcnt;
      pix = !s1_active ? 12'h000 : lit ? rd_span.color : BG_COLOR;
   end
   // registered pins, two pixel strobes after the counters
   always_ff @(posedge clk)
      if (rst) begin
         vga_hs <= 1'b1;
         vga_vs <= 1'b1;
         {vga_r, vga_g, vga_b} <= '0;
      end else if (pix_en) begin
         vga_hs <= s1_hs;
         vga_vs <= s1_vs;
         {vga_r, vga_g, vga_b} <= pix;
      end
endmodule

// File: tb/tb_column_scanout.sv
// tb_column_scanout: reduced-raster bench with a frame-level pixel model and literal anchors
module tb_column_scanout;
   localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
   localparam int VA = 10, VFP = 2, VSY = 2, VBP = 2;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int F = HT * VT;
   localparam logic [11:0] BG = 12'h012;
   logic clk = 0, rst = 1, pix_en = 0, col_valid = 0, frame_done = 0;
   logic col_ready, frame_swap, vga_hs, vga_vs;
   logic [9:0] col_x = '0;
   logic [8:0] col_start = '0, col_end = '0;
   logic [11:0] col_color = '0;
   logic [3:0] vga_r, vga_g, vga_b;
   int n_chk = 0, n_fail = 0, pc = 0;
   int ticks = 0;
   bit armed = 0, m_front = 0, m_pend = 0, m_shown = 0;
   int sp_s [2][HA];
   int sp_e [2][HA];
   int sp_c [2][HA];
   int colcnt [16][4096];
   int hs_low [16];
   int vs_low [16];
   int first_f00 [16];
   int swaps = 0, swap_tick = -1;

   column_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .col_valid(col_valid), .col_ready(col_ready),
      .col_x(col_x), .col_start(col_start), .col_end(col_end), .col_color(col_color),
      .frame_done(frame_done), .frame_swap(frame_swap), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      pix_en = (pc == 3);
      pc = (pc + 1) % 4;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // frame-level model: pixel-tick count since reset, bank contents and swap bookkeeping
   always @(posedge clk) begin
      if (rst) begin
         armed <= 1;
         ticks <= 0;
         m_front <= 0;
         m_pend <= 0;
         m_shown <= 0;
      end else begin
         if (col_valid && !m_pend && int'(col_x) < HA) begin
            sp_s[!m_front][int'(col_x)] <= int'(col_start);
            sp_e[!m_front][int'(col_x)] <= int'(col_end);
            sp_c[!m_front][int'(col_x)] <= int'(col_color);
         end
         if (pix_en && ticks % F == VA * HT && m_pend) begin
            m_front <= !m_front;
            m_pend <= 0;
            m_shown <= 1;
         end else if (frame_done) m_pend <= 1;
         if (pix_en) ticks <= ticks + 1;
      end
   end

   // per-cycle comparison: pins show the raster position two pixel ticks back
   always @(negedge clk) begin
      int q, h, v, c;
      logic [13:0] e;
      if (armed) begin
         if (ticks < 2) e = 14'h3000;
         else begin
            q = (ticks - 2) % F;
            h = q % HT;
            v = q / HT;
            c = (h < HA && v < VA) ? ((m_shown && v >= sp_s[m_front][h] && v < sp_e[m_front][h]) ? sp_c[m_front][h] : int'(BG)) : 0;
            e = {!(h >= HA + HFP && h < HA + HFP + HSY), !(v >= VA + VFP && v < VA + VFP + VSY), 12'(c)};
         end
         check("pins", 32'({vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'(e));
         check("col_ready", 32'(col_ready), 32'(!m_pend));
         check("frame_swap", 32'(frame_swap), 32'(!rst && pix_en && ticks % F == VA * HT && m_pend));
      end
   end

   // per-frame tallies of what reached the pins, one sample per pixel tick
   always @(negedge clk) begin
      int fi;
      logic [11:0] c;
      if (frame_swap) begin
         swaps++;
         swap_tick = ticks;
      end
      if (armed && !rst && pix_en && ticks >= 2 && (ticks - 2) / F < 16) begin
         fi = (ticks - 2) / F;
         c = {vga_r, vga_g, vga_b};
         colcnt[fi][c]++;
         if (!vga_hs) hs_low[fi]++;
         if (!vga_vs) vs_low[fi]++;
         if (c == 12'hF00 && first_f00[fi] < 0) first_f00[fi] = ticks;
      end
   end

   task automatic wait_tick(input int t);
      int b = 0;
      while (ticks != t && b < 20000) begin
         @(negedge clk);
         b++;
      end
      check("wait_tick", ticks, t);
   endtask

   task automatic put_col(input int x, input int s, input int e, input logic [11:0] c);
      @(posedge clk);
      #1;
      col_valid = 1;
      col_x = 10'(x);
      col_start = 9'(s);
      col_end = 9'(e);
      col_color = c;
   endtask

   task automatic pulse_done();
      @(posedge clk);
      #1;
      col_valid = 0;
      frame_done = 1;
      @(posedge clk);
      #1;
      frame_done = 0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) first_f00[i] = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_pins", 32'({vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'h3000);
      check("reset_ready", 32'(col_ready), 1);
      check("reset_swap", 32'(frame_swap), 0);
      @(posedge clk);
      #1;
      rst = 0;
      wait_tick(2 + F);
      check("f0_hs_low", hs_low[0], 48);
      check("f0_vs_low", vs_low[0], 48);
      check("f0_bg", colcnt[0][BG], 160);
      check("f0_blank", colcnt[0][0], 224);
      for (int x = 0; x < HA; x++) put_col(x, 3, 7, 12'hF00);
      pulse_done();
      wait_tick(2 + 3 * F);
      check("swap1_tick", swap_tick, 624);
      check("swap1_count", swaps, 1);
      check("f2_red", colcnt[2][12'hF00], 64);
      check("f2_bg", colcnt[2][BG], 96);
      check("latency", first_f00[2] % F, 74);
      for (int x = 0; x < HA; x++) put_col(x, 1, 5, 12'h0F0);
      pulse_done();
      @(posedge clk);
      #1;
      col_valid = 1;
      col_x = 10'd2;
      col_start = 9'd0;
      col_end = 9'd10;
      col_color = 12'h00F;
      @(negedge clk);
      check("held_ready_low", 32'(col_ready), 0);
      n = 0;
      while (!col_ready && n < 4 * F) begin
         @(negedge clk);
         n++;
      end
      check("held_swap_first", swaps, 2);
      check("held_ready_back", 32'(col_ready), 1);
      @(posedge clk);
      #1;
      col_valid = 0;
      wait_tick(2 + 5 * F);
      check("swap2_tick", swap_tick, 1392);
      check("f4_green", colcnt[4][12'h0F0], 64);
      check("f4_held_hidden", colcnt[4][12'h00F], 0);
      for (int x = 0; x < HA; x++) put_col(x, 2, 8, 12'hFF0);
      put_col(5, 8, 2, 12'hABC);
      put_col(700, 0, 10, 12'h123);
      pulse_done();
      wait_tick(2 + 7 * F);
      check("swap3_tick", swap_tick, 2160);
      check("f6_yellow", colcnt[6][12'hFF0], 90);
      check("f6_bg", colcnt[6][BG], 70);
      check("f6_dropped", colcnt[6][12'h123], 0);
      check("f6_empty", colcnt[6][12'hABC], 0);
      put_col(0, 1, 2, 12'h555);
      pulse_done();
      wait_tick(7 * F + 5 * HT);
      check("pend_before_rst", 32'(col_ready), 0);
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(col_ready), 1);
      check("rst_pins", 32'({vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'h3000);
      @(posedge clk);
      #1;
      rst = 0;
      wait_tick(F + 10);
      check("rst_no_swap", swaps, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
